// File: rtl/commutation_controller_pkg.sv
// commutation_pkg: shared types and helpers for the six-step BLDC commutation
// controller.
//   state_e      - controller FSM state (also exported for observation)
//   FAULT_*      - latched fault-code values
//   comm_entry_t - one commutation table row (step, high-side u, float z)
//   hall_legal   - 000 and 111 are not produced by a healthy sensor set
//   step_lookup  - forward commutation table, hall code -> row
//   step_delta   - forward distance between two steps, modulo 6
//   drive_u      - high-side pattern for the requested direction
package commutation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEADTIME = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_JUMP    = 2'b10;
  localparam logic [1:0] FAULT_STALL   = 2'b11;

  localparam logic [2:0] FLOAT_U = 3'b000;
  localparam logic [2:0] FLOAT_Z = 3'b111;

  typedef struct packed {
    logic [2:0] step;
    logic [2:0] u;
    logic [2:0] z;
  } comm_entry_t;

  function automatic logic hall_legal(input logic [2:0] code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

  function automatic comm_entry_t step_lookup(input logic [2:0] code);
    comm_entry_t e;
    e = '{step: 3'd0, u: FLOAT_U, z: FLOAT_Z};
    case (code)
      3'b101:  e = '{step: 3'd0, u: 3'b001, z: 3'b100};
      3'b100:  e = '{step: 3'd1, u: 3'b001, z: 3'b010};
      3'b110:  e = '{step: 3'd2, u: 3'b010, z: 3'b001};
      3'b010:  e = '{step: 3'd3, u: 3'b010, z: 3'b100};
      3'b011:  e = '{step: 3'd4, u: 3'b100, z: 3'b010};
      3'b001:  e = '{step: 3'd5, u: 3'b100, z: 3'b001};
      default: e = '{step: 3'd0, u: FLOAT_U, z: FLOAT_Z};
    endcase
    return e;
  endfunction

  // 1 = one step forward, 5 = one step back, 2..4 = a skipped position.
  function automatic logic [2:0] step_delta(input logic [2:0] from_step,
                                            input logic [2:0] to_step);
    logic [3:0] t;
    t = {1'b0, to_step} + 4'd6 - {1'b0, from_step};
    if (t >= 4'd6) t = t - 4'd6;
    return t[2:0];
  endfunction

  // Reverse keeps the floating phase and swaps the high and low phases.
  function automatic logic [2:0] drive_u(input comm_entry_t e, input logic dir);
    return dir ? (~e.u & ~e.z) : e.u;
  endfunction

endpackage

// File: rtl/commutation_controller_if.sv
// commutation_controller_if: pin-level bundle between the controller and its
// surroundings.
//   hall/enable/dir/fault_clr - inputs to the controller
//   u/z/step                  - phase-driver pattern and current table step
//   period/period_valid       - hall-edge period measurement
//   fault/fault_code          - latched fault status
//   state                     - controller FSM state, for observation
// Handshake: there is no valid/ready flow control; period_valid is a
// one-cycle strobe meaning "period was just updated", all other outputs are
// level signals that are valid every cycle.
interface commutation_controller_if #(
  parameter int PERIOD_W = 24
);
  import commutation_pkg::*;

  logic [2:0]          hall;
  logic                enable;
  logic                dir;
  logic                fault_clr;
  logic [2:0]          u;
  logic [2:0]          z;
  logic [2:0]          step;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                fault;
  logic [1:0]          fault_code;
  state_e              state;

  modport master (
    output hall, enable, dir, fault_clr,
    input  u, z, step, period, period_valid, fault, fault_code, state
  );

  modport slave (
    input  hall, enable, dir, fault_clr,
    output u, z, step, period, period_valid, fault, fault_code, state
  );

endinterface

// File: rtl/commutation_controller_hall_debounce.sv
// hall_debounce: two-flop synchronizer plus debouncer for the 3-bit hall code.
//   clk, rst_n - clock, asynchronous active-low reset
//   hall_raw   - raw hall pins, asynchronous to clk
//   hall_f     - filtered code; changes only after the synchronized code has
//                held a new value for DEBOUNCE_CYCLES consecutive samples
module hall_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hall_raw,
  output logic [2:0] hall_f
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       hall_f_q, hall_f_d;
  logic [CNT_W-1:0] run_cnt;

  always_comb begin
    sync1_d  = hall_raw;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    hall_f_d = hall_f_q;
    // Length of the current run of identical synchronized samples.
    run_cnt  = (sync2_q == cand_q) ? cnt_q + 1'b1 : CNT_W'(1);
    if (sync2_q == hall_f_q) begin
      cand_d = hall_f_q;
      cnt_d  = '0;
    end else if (run_cnt >= CNT_TARGET) begin
      hall_f_d = sync2_q;
      cand_d   = sync2_q;
      cnt_d    = '0;
    end else begin
      cand_d = sync2_q;
      cnt_d  = run_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      cand_q   <= 3'b000;
      cnt_q    <= '0;
      hall_f_q <= 3'b000;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      hall_f_q <= hall_f_d;
    end
  end

  assign hall_f = hall_f_q;

endmodule

// File: rtl/commutation_controller.sv
// commutation_controller: six-step BLDC commutation sequencer.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of commutation_controller_if:
//                hall/enable/dir/fault_clr in; u/z/step, period/period_valid,
//                fault/fault_code and FSM state out (all registered)
// Filters the hall code, checks code legality and sequence, applies the
// commutation table in the commanded direction with a floating dead-time gap
// at every commutation, measures the hall-edge period and latches faults.
module commutation_controller
  import commutation_pkg::*;
#(
  parameter int                  DEBOUNCE_CYCLES = 4,
  parameter int                  DEADTIME_CYCLES = 8,
  parameter int                  PERIOD_W        = 24,
  parameter logic [PERIOD_W-1:0] STALL_LIMIT     = '1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  commutation_controller_if.slave  bus
);

  localparam int DT_W = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME_CYCLES - 1);

  logic [2:0] hall_f;

  hall_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hall_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .hall_raw(bus.hall),
    .hall_f  (hall_f)
  );

  state_e              state_q, state_d;
  logic [DT_W-1:0]     dt_cnt_q, dt_cnt_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic                has_ref_q, has_ref_d;     // a reference hall edge exists
  logic                drive_dir_q, drive_dir_d; // dir the current pattern uses
  logic [2:0]          u_q, u_d;
  logic [2:0]          z_q, z_d;
  logic [2:0]          step_q, step_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                period_valid_q, period_valid_d;
  logic                fault_q, fault_d;
  logic [1:0]          fault_code_q, fault_code_d;

  comm_entry_t         entry;
  logic [2:0]          delta;
  logic [PERIOD_W-1:0] per_cnt_inc;
  logic                fault_hit;
  logic [1:0]          fault_kind;

  always_comb begin
    state_d        = state_q;
    dt_cnt_d       = dt_cnt_q;
    per_cnt_d      = per_cnt_q;
    has_ref_d      = has_ref_q;
    drive_dir_d    = drive_dir_q;
    u_d            = u_q;
    z_d            = z_q;
    step_d         = step_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    fault_d        = fault_q;
    fault_code_d   = fault_code_q;
    fault_hit      = 1'b0;
    fault_kind     = FAULT_NONE;

    entry       = step_lookup(hall_f);
    delta       = step_delta(step_q, entry.step);
    per_cnt_inc = (&per_cnt_q) ? per_cnt_q : per_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        u_d       = FLOAT_U;
        z_d       = FLOAT_Z;
        per_cnt_d = '0;
        has_ref_d = 1'b0;
        if (bus.enable && hall_legal(hall_f)) begin
          state_d  = ST_DEADTIME;
          dt_cnt_d = '0;
          step_d   = entry.step;
        end
      end

      ST_DEADTIME, ST_DRIVE: begin
        per_cnt_d = per_cnt_inc;
        if (!bus.enable) begin
          state_d   = ST_IDLE;
          u_d       = FLOAT_U;
          z_d       = FLOAT_Z;
          per_cnt_d = '0;
          has_ref_d = 1'b0;
        end else if (!hall_legal(hall_f)) begin
          fault_hit  = 1'b1;
          fault_kind = FAULT_ILLEGAL;
        end else if (delta inside {3'd2, 3'd3, 3'd4}) begin
          fault_hit  = 1'b1;
          fault_kind = FAULT_JUMP;
        end else if (delta != 3'd0) begin
          // Accepted commutation: float, (re)start the gap, take a period sample.
          state_d   = ST_DEADTIME;
          dt_cnt_d  = '0;
          u_d       = FLOAT_U;
          z_d       = FLOAT_Z;
          step_d    = entry.step;
          per_cnt_d = '0;
          has_ref_d = 1'b1;
          if (has_ref_q) begin
            period_d       = per_cnt_inc;
            period_valid_d = 1'b1;
          end
        end else if (state_q == ST_DRIVE && per_cnt_q >= STALL_LIMIT) begin
          fault_hit  = 1'b1;
          fault_kind = FAULT_STALL;
        end else if (state_q == ST_DRIVE && bus.dir != drive_dir_q) begin
          state_d  = ST_DEADTIME;
          dt_cnt_d = '0;
          u_d      = FLOAT_U;
          z_d      = FLOAT_Z;
        end else if (state_q == ST_DEADTIME) begin
          if (dt_cnt_q == DT_LAST) begin
            state_d     = ST_DRIVE;
            drive_dir_d = bus.dir;
            u_d         = drive_u(entry, bus.dir);
            z_d         = entry.z;
          end else begin
            dt_cnt_d = dt_cnt_q + 1'b1;
          end
        end

        if (fault_hit) begin
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_code_d = fault_kind;
          u_d          = FLOAT_U;
          z_d          = FLOAT_Z;
          per_cnt_d    = '0;
          has_ref_d    = 1'b0;
        end
      end

      ST_FAULT: begin
        u_d       = FLOAT_U;
        z_d       = FLOAT_Z;
        per_cnt_d = '0;
        has_ref_d = 1'b0;
        if (bus.fault_clr && !bus.enable) begin
          state_d      = ST_IDLE;
          fault_d      = 1'b0;
          fault_code_d = FAULT_NONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      dt_cnt_q       <= '0;
      per_cnt_q      <= '0;
      has_ref_q      <= 1'b0;
      drive_dir_q    <= 1'b0;
      u_q            <= FLOAT_U;
      z_q            <= FLOAT_Z;
      step_q         <= 3'd0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      fault_q        <= 1'b0;
      fault_code_q   <= FAULT_NONE;
    end else begin
      state_q        <= state_d;
      dt_cnt_q       <= dt_cnt_d;
      per_cnt_q      <= per_cnt_d;
      has_ref_q      <= has_ref_d;
      drive_dir_q    <= drive_dir_d;
      u_q            <= u_d;
      z_q            <= z_d;
      step_q         <= step_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      fault_q        <= fault_d;
      fault_code_q   <= fault_code_d;
    end
  end

  assign bus.u            = u_q;
  assign bus.z            = z_q;
  assign bus.step         = step_q;
  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.fault        = fault_q;
  assign bus.fault_code   = fault_code_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_commutation_controller.sv
// tb_commutation_controller: directed bench for commutation_controller with
// DEBOUNCE_CYCLES=4, DEADTIME_CYCLES=8 and STALL_LIMIT=1000. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_commutation_controller;
  import commutation_pkg::*;

  localparam int PERIOD_W = 24;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   pv_count = 0;

  commutation_controller_if #(.PERIOD_W(PERIOD_W)) bus ();

  commutation_controller #(
    .DEBOUNCE_CYCLES(4),
    .DEADTIME_CYCLES(8),
    .PERIOD_W       (PERIOD_W),
    .STALL_LIMIT    (24'd1000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Count period_valid pulses; each pulse is seen on exactly one falling edge.
  always @(negedge clk) begin
    if (bus.period_valid === 1'b1) pv_count <= pv_count + 1;
  end

  // ---------------- driver / check tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] observed,
                     input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic chk_pattern(input string tag, input logic [2:0] eu,
                             input logic [2:0] ez);
    chk({tag, "_u"}, 32'(bus.u), 32'(eu));
    chk({tag, "_z"}, 32'(bus.z), 32'(ez));
  endtask

  // ---------------- directed stimulus ----------------
  logic [2:0] seq_code [5];
  logic [2:0] seq_u    [5];
  logic [2:0] seq_z    [5];
  logic [2:0] seq_step [5];
  int         gap_cycles;
  int         pv_base;

  initial begin
    seq_code = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    seq_u    = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    seq_z    = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
    seq_step = '{3'd1,   3'd2,   3'd3,   3'd4,   3'd5};

    rst_n         = 1'b0;
    bus.hall      = 3'b000;
    bus.enable    = 1'b0;
    bus.dir       = 1'b0;
    bus.fault_clr = 1'b0;

    // Reset values
    cycles(2);
    chk_pattern("rst", 3'b000, 3'b111);
    chk("rst_step", 32'(bus.step), 32'd0);
    chk("rst_period", 32'(bus.period), 32'd0);
    chk("rst_pv", 32'(bus.period_valid), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_code", 32'(bus.fault_code), 32'd0);
    chk("rst_state", 32'(bus.state), 32'(ST_IDLE));
    rst_n = 1'b1;
    cycles(20);
    chk_pattern("idle", 3'b000, 3'b111);
    chk("idle_fault", 32'(bus.fault), 32'd0);
    chk("idle_pv_count", 32'(pv_count), 32'd0);

    // Start on hall 101: 2 sync + 4 debounce + 1 + 8 dead-time cycles
    bus.enable = 1'b1;
    bus.hall   = 3'b101;
    cycles(14);
    chk_pattern("start_gap", 3'b000, 3'b111);
    cycles(1);
    chk_pattern("start_drive", 3'b001, 3'b100);
    chk("start_step", 32'(bus.step), 32'd0);
    chk("start_state", 32'(bus.state), 32'(ST_DRIVE));

    // Two-cycle glitch to 100 must be filtered out
    bus.hall = 3'b100;
    cycles(2);
    bus.hall = 3'b101;
    gap_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      if (bus.z !== 3'b100 || bus.u !== 3'b001) gap_cycles++;
    end
    chk("glitch_gap_cycles", 32'(gap_cycles), 32'd0);
    chk("glitch_step", 32'(bus.step), 32'd0);

    // Forward sequence, each code held 100 cycles
    pv_base = pv_count;
    for (int i = 0; i < 5; i++) begin
      bus.hall = seq_code[i];
      cycles(6);
      chk("seq_pre_gap_z", 32'(bus.z !== 3'b111), 32'd1);
      cycles(1);
      chk_pattern("seq_gap_start", 3'b000, 3'b111);
      chk("seq_pv", 32'(bus.period_valid), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk("seq_period", 32'(bus.period), 32'd100);
      cycles(1);
      chk("seq_pv_single", 32'(bus.period_valid), 32'd0);
      cycles(6);
      chk_pattern("seq_gap_end", 3'b000, 3'b111);
      cycles(1);
      chk_pattern("seq_drive", seq_u[i], seq_z[i]);
      chk("seq_step", 32'(bus.step), 32'(seq_step[i]));
      cycles(85);
    end
    chk("seq_pv_total", 32'(pv_count - pv_base), 32'd4);

    // Wrap 001 -> 101, then reverse direction during step 0
    bus.hall = 3'b101;
    cycles(7);
    chk("wrap_period", 32'(bus.period), 32'd100);
    chk("wrap_pv", 32'(bus.period_valid), 32'd1);
    cycles(8);
    chk_pattern("wrap_drive", 3'b001, 3'b100);
    bus.dir = 1'b1;
    cycles(1);
    chk_pattern("dir_gap_start", 3'b000, 3'b111);
    cycles(7);
    chk_pattern("dir_gap_end", 3'b000, 3'b111);
    cycles(1);
    chk_pattern("dir_rev_drive", 3'b010, 3'b100);
    chk("dir_rev_step", 32'(bus.step), 32'd0);
    bus.dir = 1'b0;
    cycles(9);
    chk_pattern("dir_fwd_drive", 3'b001, 3'b100);

    // Illegal code while driving
    bus.hall = 3'b000;
    cycles(6);
    chk("ill_not_yet", 32'(bus.fault), 32'd0);
    cycles(1);
    chk("ill_fault", 32'(bus.fault), 32'd1);
    chk("ill_code", 32'(bus.fault_code), 32'(FAULT_ILLEGAL));
    chk_pattern("ill_float", 3'b000, 3'b111);
    chk("ill_state", 32'(bus.state), 32'(ST_FAULT));
    bus.fault_clr = 1'b1;
    cycles(3);
    chk("clr_while_enabled", 32'(bus.fault), 32'd1);
    bus.fault_clr = 1'b0;
    bus.enable    = 1'b0;
    cycles(2);
    chk("disable_keeps_fault", 32'(bus.fault), 32'd1);
    bus.fault_clr = 1'b1;
    cycles(1);
    chk("clr_fault", 32'(bus.fault), 32'd0);
    chk("clr_code", 32'(bus.fault_code), 32'd0);
    chk("clr_state", 32'(bus.state), 32'(ST_IDLE));
    bus.fault_clr = 1'b0;

    // Sequence jump 101 -> 110
    bus.hall   = 3'b101;
    bus.enable = 1'b1;
    cycles(15);
    chk_pattern("jump_pre_drive", 3'b001, 3'b100);
    bus.hall = 3'b110;
    cycles(7);
    chk("jump_fault", 32'(bus.fault), 32'd1);
    chk("jump_code", 32'(bus.fault_code), 32'(FAULT_JUMP));
    bus.enable    = 1'b0;
    bus.fault_clr = 1'b1;
    cycles(1);
    chk("jump_clr", 32'(bus.fault), 32'd0);
    bus.fault_clr = 1'b0;

    // Stall: hall frozen at 110 with STALL_LIMIT=1000
    bus.enable = 1'b1;
    cycles(9);
    chk_pattern("stall_drive", 3'b010, 3'b001);
    chk("stall_step", 32'(bus.step), 32'd2);
    cycles(992);
    chk("stall_not_yet", 32'(bus.fault), 32'd0);
    cycles(1);
    chk("stall_fault", 32'(bus.fault), 32'd1);
    chk("stall_code", 32'(bus.fault_code), 32'(FAULT_STALL));
    chk_pattern("stall_float", 3'b000, 3'b111);
    bus.enable    = 1'b0;
    bus.fault_clr = 1'b1;
    cycles(1);
    bus.fault_clr = 1'b0;

    // enable falling floats the outputs on the next edge
    bus.enable = 1'b1;
    cycles(9);
    chk_pattern("en_drive", 3'b010, 3'b001);
    bus.enable = 1'b0;
    cycles(1);
    chk_pattern("en_fall_float", 3'b000, 3'b111);
    chk("en_fall_state", 32'(bus.state), 32'(ST_IDLE));
    chk("final_pv_count", 32'(pv_count), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
